stage_sequencer: RTL and testbench
==================================

# stage_sequencer

Parametrised successor to the CPU stage counter. Sequences a multi-cycle instruction through `NUM_STAGES` stages, with:
- stall, flush and early-completion control from the CPU;
- binary and one-hot stage outputs;
- a retire pulse and a retired-instruction counter.

Sits in the top level beside `ram` and `riscv_cpu` and replaces the free-running stage counter.

## Interface
Parameters:
- `NUM_STAGES`, default 5: number of stages, legal range ≥ 1.
- `STAGE_W`, default 3: width of `stage_o`. Must satisfy `2**STAGE_W >= NUM_STAGES`; violation is an elaboration `$error`.
- `RETIRE_W`, default 32: width of the retire counter.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `stall`  in  1: hold current stage.
- `flush`  in  1: abandon current instruction, return to stage 0.
- `done_early`  in  1: current instruction completes at the current stage.
- `stage_o`  out  `STAGE_W`: current stage index, 0..`NUM_STAGES`-1.
- `stage_onehot_o`  out  `NUM_STAGES`: bit `stage_o` set, all others clear.
- `last_stage_o`  out  1: high when `stage_o == NUM_STAGES-1`.
- `retire_o`  out  1: one-cycle pulse following a completing edge.
- `retire_count_o`  out  `RETIRE_W`: number of retired instructions.

## Operation
Reset values, set while `reset`=0 independent of `clk`:
- `stage_o`=0, `stage_onehot_o`=1, `last_stage_o`=(`NUM_STAGES`==1), `retire_o`=0, `retire_count_o`=0.

Next-state priority at each rising edge, highest first:
1. `flush`: stage ← 0. No retire, even if at the last stage.
2. `stall`: stage holds. No retire.
3. `done_early` or `last_stage_o`: instruction completes. Stage ← 0, `retire_o` ← 1, counter += 1.
4. Otherwise: stage ← stage+1, `retire_o` ← 0.

Further rules:
- `retire_o` ← 0 on every edge where the instruction does not complete.
- The counter wraps modulo 2^`RETIRE_W`; there is no saturation.
- `stage_o` never takes a value ≥ `NUM_STAGES`, including for non-power-of-two depths.
- `done_early` at stage 0 is a legal one-cycle instruction: the stage stays 0 and the instruction retires.
- `NUM_STAGES`=1: every edge without flush or stall retires, and `last_stage_o` is constantly 1.
- Reset asserted mid-instruction discards it immediately; no retire is counted.
- Outputs are registered or decoded only from registered state. There are no combinational paths from inputs to outputs.

## Timing
- Control inputs are sampled at the rising edge and take effect on outputs in that same edge's cycle (1-cycle latency).
- `retire_o` is high exactly during the cycle after the completing edge. `retire_count_o` shows the incremented value in that same cycle.
- Back-to-back completions, e.g. `NUM_STAGES`=1 or `done_early` held at stage 0, give `retire_o` high continuously with the count incrementing every cycle.
- Reset deassertion is synchronised externally; the first edge after deassertion advances 0→1 unless stalled or flushed.

## Configuration
- `STAGE_RETIRE_CNT_EN` defined: the `RETIRE_W`-bit counter is built and `retire_count_o` behaves as described above.
- Not defined: no counter flops exist and `retire_count_o` is tied to 0. Port list is unchanged; `retire_o` behaviour is unchanged.

## Test plan
- **Free run:** `NUM_STAGES`=5, all controls low, 12 edges after reset.
  - `stage_o` sequence is 1,2,3,4,0,1,2,3,4,0,1,2.
  - `retire_o` is high in the cycles where `stage_o`=0.
  - `retire_count_o`=2.
- **Stall/flush priority:** reach stage 3, assert `stall`+`flush` together for one edge.
  - `stage_o`=0, `retire_o`=0, count unchanged.
  - Then `stall` alone for 3 edges: `stage_o` stays 0.
- **Early completion:** `done_early` at stage 2.
  - Next cycle `stage_o`=0, `retire_o`=1, count +1.
  - `done_early` held at stage 0 gives `retire_o`=1 every cycle.
- **Non-power-of-two and wrap:** `NUM_STAGES`=3, `STAGE_W`=2, `RETIRE_W`=4, run 48 edges.
  - `stage_o` is never 3.
  - `retire_count_o` wraps 15→0 and ends at 0 (16 retires).
- **Async reset mid-instruction:** at stage 3, pull `reset` low between edges.
  - Outputs go to reset values before the next edge.
  - After release, count restarts from 0.
- **Macro off:** build without `STAGE_RETIRE_CNT_EN` and repeat the free-run test.
  - `retire_count_o`=0 throughout.
  - `retire_o` pattern is identical to the first test.

Source files
------------

// File: rtl/stage_sequencer.sv
// Stage sequencer: walks an instruction through NUM_STAGES stages with stall/flush/early-done.
// Define STAGE_RETIRE_CNT_EN to build the retired-instruction counter; otherwise it reads 0.
module stage_sequencer #(
    parameter int NUM_STAGES = 5,
    parameter int STAGE_W    = 3,
    parameter int RETIRE_W   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  done_early,
    output logic [STAGE_W-1:0]    stage_o,
    output logic [NUM_STAGES-1:0] stage_onehot_o,
    output logic                  last_stage_o,
    output logic                  retire_o,
    output logic [RETIRE_W-1:0]   retire_count_o
);

    if (NUM_STAGES < 1) begin : g_bad_depth
        $error("stage_sequencer: NUM_STAGES must be >= 1");
    end
    if ((2 ** STAGE_W) < NUM_STAGES) begin : g_bad_width
        $error("stage_sequencer: STAGE_W too narrow for NUM_STAGES");
    end

    localparam logic [STAGE_W-1:0] LAST = STAGE_W'(NUM_STAGES - 1);

    logic [STAGE_W-1:0] stage_nxt;
    logic               complete;

    // Completion is lower priority than both flush and stall.
    assign complete = !flush && !stall && (done_early || last_stage_o);

    always_comb begin
        stage_nxt = stage_o;
        if (flush)         stage_nxt = '0;
        else if (stall)    stage_nxt = stage_o;
        else if (complete) stage_nxt = '0;
        else               stage_nxt = stage_o + STAGE_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_o  <= '0;
            retire_o <= 1'b0;
        end else begin
            stage_o  <= stage_nxt;
            retire_o <= complete;
        end
    end

    assign last_stage_o = (stage_o == LAST);

    always_comb begin
        stage_onehot_o = '0;
        for (int i = 0; i < NUM_STAGES; i++)
            stage_onehot_o[i] = (stage_o == STAGE_W'(i));
    end

`ifdef STAGE_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        retire_count_o <= '0;
        else if (complete) retire_count_o <= retire_count_o + RETIRE_W'(1);
    end
`else
    assign retire_count_o = '0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: three depths (5, 3, 1) on shared controls against a rule-level model.
module tb_stage_sequencer;

    logic clk = 1'b0;
    logic reset, stall, flush, done_early;

    logic [2:0]  s5; logic [4:0] oh5; logic l5, r5; logic [31:0] c5;
    logic [1:0]  s3; logic [2:0] oh3; logic l3, r3; logic [3:0]  c3;
    logic [0:0]  s1; logic [0:0] oh1; logic l1, r1; logic [31:0] c1;

    stage_sequencer #(.NUM_STAGES(5), .STAGE_W(3), .RETIRE_W(32)) u5 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .done_early(done_early),
        .stage_o(s5), .stage_onehot_o(oh5), .last_stage_o(l5), .retire_o(r5), .retire_count_o(c5));
    stage_sequencer #(.NUM_STAGES(3), .STAGE_W(2), .RETIRE_W(4)) u3 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .done_early(done_early),
        .stage_o(s3), .stage_onehot_o(oh3), .last_stage_o(l3), .retire_o(r3), .retire_count_o(c3));
    stage_sequencer #(.NUM_STAGES(1), .STAGE_W(1), .RETIRE_W(32)) u1 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .done_early(done_early),
        .stage_o(s1), .stage_onehot_o(oh1), .last_stage_o(l1), .retire_o(r1), .retire_count_o(c1));

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Reference model: one instruction in flight, stage index and retire tally per depth.
    int     depth [3] = '{5, 3, 1};
    int     rw    [3] = '{32, 4, 32};
    int     m_stage [3];
    bit     m_ret   [3];
    longint m_cnt   [3];

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_stage[k] = 0; m_ret[k] = 0; m_cnt[k] = 0;
        end
    endfunction

    function automatic void model_edge(input bit s, input bit f, input bit d);
        for (int k = 0; k < 3; k++) begin
            m_ret[k] = 0;
            if (f) m_stage[k] = 0;
            else if (s) ;
            else if (d || m_stage[k] == depth[k] - 1) begin
                m_stage[k] = 0;
                m_ret[k]   = 1;
                m_cnt[k]   = (m_cnt[k] + 1) % (longint'(1) << rw[k]);
            end else m_stage[k]++;
        end
    endfunction

    function automatic longint exp_cnt(input int k);
`ifdef STAGE_RETIRE_CNT_EN
        return m_cnt[k];
`else
        return 0;
`endif
    endfunction

    task automatic check_dut(input int k, input longint st, input longint oh, input longint l,
                             input longint r, input longint c);
        chk($sformatf("d%0d_stage", depth[k]), st, m_stage[k]);
        chk($sformatf("d%0d_onehot", depth[k]), oh, longint'(1) << m_stage[k]);
        chk($sformatf("d%0d_last", depth[k]), l, longint'(m_stage[k] == depth[k] - 1));
        chk($sformatf("d%0d_retire", depth[k]), r, longint'(m_ret[k]));
        chk($sformatf("d%0d_count", depth[k]), c, exp_cnt(k));
    endtask

    task automatic check_all();
        check_dut(0, s5, oh5, l5, r5, c5);
        check_dut(1, s3, oh3, l3, r3, c3);
        check_dut(2, s1, oh1, l1, r1, c1);
    endtask

    task automatic step(input bit s, input bit f, input bit d);
        stall = s; flush = f; done_early = d;
        @(posedge clk);
        model_edge(s, f, d);
        #1;
        check_all();
    endtask

    task automatic async_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    int fr [12] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2};
    int n3_ret;

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0; done_early = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b1;

        // Free run: 12 edges, then on to 48 for the depth-3 counter wrap.
        n3_ret = 0;
        for (int i = 0; i < 48; i++) begin
            step(0, 0, 0);
            if (r3) n3_ret++;
            chk("d3_stage_lt3", longint'(s3 < 2'd3), 1);
            if (i < 12) begin
                chk("fr_stage", s5, fr[i]);
                chk("fr_retire", r5, longint'(fr[i] == 0));
            end
            if (i == 11) begin
`ifdef STAGE_RETIRE_CNT_EN
                chk("fr_count12", c5, 2);
`else
                chk("fr_count12", c5, 0);
`endif
            end
        end
        chk("d3_retires48", n3_ret, 16);
        chk("d3_count_wrap", c3, 0);

        // Depth 5 now sits at stage 3: flush beats stall, then stall holds.
        chk("pre_flush_stage", s5, 3);
        step(1, 1, 0);
        chk("sf_stage", s5, 0);
        chk("sf_retire", r5, 0);
        repeat (3) begin
            step(1, 0, 0);
            chk("stall_stage", s5, 0);
        end

        // Early completion at stage 2, then held at stage 0.
        step(0, 0, 0); step(0, 0, 0);
        chk("pre_early_stage", s5, 2);
        step(0, 0, 1);
        chk("early_stage", s5, 0);
        chk("early_retire", r5, 1);
        repeat (3) begin
            step(0, 0, 1);
            chk("early_hold_retire", r5, 1);
        end

        // Reset between edges at stage 3.
        step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
        chk("pre_rst_stage", s5, 3);
        async_reset();
        chk("rst_count", c5, 0);
        step(0, 0, 0);
        chk("post_rst_stage", s5, 1);

        // Random control mix with occasional asynchronous reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 1) async_reset();
            else step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
                      $urandom_range(0, 99) < 20);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
